// File: rtl/parity_frame_tx.sv
// Serial frame transmitter: start bit, data LSB-first, supplied parity bit, stop bit.
// Also flags accepted words whose supplied parity disagrees with the data.
module parity_frame_tx #(
  parameter int unsigned DATA_WIDTH   = 8,
  parameter int unsigned CLKS_PER_BIT = 4,
  parameter int unsigned PARITY_ODD   = 0
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [DATA_WIDTH-1:0] data_in,
  input  logic                  parity_in,
  input  logic                  in_valid,
  output logic                  in_ready,
  output logic                  tx_serial,
  output logic                  busy,
  output logic                  frame_done,
  output logic                  parity_err
);

  localparam int unsigned BAUD_W = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
  localparam int unsigned IDX_W  = (DATA_WIDTH > 1) ? $clog2(DATA_WIDTH) : 1;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    START  = 3'd1,
    DATA   = 3'd2,
    PARITY = 3'd3,
    STOP   = 3'd4
  } state_e;

  state_e                state_q;
  logic [BAUD_W-1:0]     baud_q;
  logic [IDX_W-1:0]      idx_q;
  logic [DATA_WIDTH-1:0] shift_q;
  logic                  par_q;
  logic                  tx_q;
  logic                  busy_q;
  logic                  done_q;
  logic                  err_q;

  logic [DATA_WIDTH-1:0] shift_d;
  logic                  bit_end_c;
  logic                  last_idx_c;
  logic                  expected_par_c;

  assign shift_d        = shift_q >> 1;
  assign bit_end_c      = (baud_q == BAUD_W'(CLKS_PER_BIT - 1));
  assign last_idx_c     = (idx_q == IDX_W'(DATA_WIDTH - 1));
  assign expected_par_c = (^data_in) ^ 1'(PARITY_ODD);

  assign in_ready   = (state_q == IDLE) && !rst;
  assign tx_serial  = tx_q;
  assign busy       = busy_q;
  assign frame_done = done_q;
  assign parity_err = err_q;

  // tx_q is loaded on each transition with the level of the state being entered.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      baud_q  <= '0;
      idx_q   <= '0;
      shift_q <= '0;
      par_q   <= 1'b0;
      tx_q    <= 1'b1;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      done_q <= 1'b0;
      case (state_q)
        IDLE: begin
          if (in_valid) begin
            shift_q <= data_in;
            par_q   <= parity_in;
            err_q   <= (parity_in != expected_par_c);
            baud_q  <= '0;
            idx_q   <= '0;
            tx_q    <= 1'b0;
            busy_q  <= 1'b1;
            state_q <= START;
          end
        end
        START: begin
          if (bit_end_c) begin
            baud_q  <= '0;
            tx_q    <= shift_q[0];
            state_q <= DATA;
          end else begin
            baud_q <= baud_q + BAUD_W'(1);
          end
        end
        DATA: begin
          if (bit_end_c) begin
            baud_q <= '0;
            if (last_idx_c) begin
              tx_q    <= par_q;
              state_q <= PARITY;
            end else begin
              idx_q   <= idx_q + IDX_W'(1);
              shift_q <= shift_d;
              tx_q    <= shift_d[0];
            end
          end else begin
            baud_q <= baud_q + BAUD_W'(1);
          end
        end
        PARITY: begin
          if (bit_end_c) begin
            baud_q  <= '0;
            tx_q    <= 1'b1;
            state_q <= STOP;
          end else begin
            baud_q <= baud_q + BAUD_W'(1);
          end
        end
        STOP: begin
          if (bit_end_c) begin
            baud_q  <= '0;
            tx_q    <= 1'b1;
            busy_q  <= 1'b0;
            done_q  <= 1'b1;
            state_q <= IDLE;
          end else begin
            baud_q <= baud_q + BAUD_W'(1);
          end
        end
        default: begin
          baud_q  <= '0;
          tx_q    <= 1'b1;
          busy_q  <= 1'b0;
          state_q <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_parity_frame_tx.sv
// Bench for parity_frame_tx: directed table, hand sequences and random frames
// against a slot-based frame model; a second instance covers odd parity at one clock per bit.
module tb_parity_frame_tx;

  localparam int unsigned W     = 8;
  localparam int unsigned CPB   = 4;
  localparam int          FRAME = (W + 3) * CPB;

  logic         clk = 1'b0;
  logic         rst;
  logic [W-1:0] data_in;
  logic         parity_in;
  logic         in_valid;
  logic         in_ready;
  logic         tx_serial;
  logic         busy;
  logic         frame_done;
  logic         parity_err;

  logic [W-1:0] o_data;
  logic         o_par;
  logic         o_valid;
  logic         o_ready;
  logic         o_tx;
  logic         o_busy;
  logic         o_done;
  logic         o_err;

  int n_tests = 0;
  int n_fail  = 0;

  typedef struct {
    logic [W-1:0] d;
    logic         p;
    logic         e;
    int           pulse;
  } vec_t;

  vec_t vecs[5];

  parity_frame_tx #(.DATA_WIDTH(W), .CLKS_PER_BIT(CPB), .PARITY_ODD(0)) dut (
    .clk(clk), .rst(rst), .data_in(data_in), .parity_in(parity_in),
    .in_valid(in_valid), .in_ready(in_ready), .tx_serial(tx_serial),
    .busy(busy), .frame_done(frame_done), .parity_err(parity_err)
  );

  parity_frame_tx #(.DATA_WIDTH(W), .CLKS_PER_BIT(1), .PARITY_ODD(1)) dut_odd (
    .clk(clk), .rst(rst), .data_in(o_data), .parity_in(o_par),
    .in_valid(o_valid), .in_ready(o_ready), .tx_serial(o_tx),
    .busy(o_busy), .frame_done(o_done), .parity_err(o_err)
  );

  always #5 clk = ~clk;

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish, got timeout required completion");
    $fatal(1);
  end

  task automatic check(input string name, input logic act, input logic exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %b expected %b at %0t", name, act, exp, $time);
    end
  endtask

  // Line level during bit slot k of a frame: 0 start, data LSB first, parity, stop.
  function automatic logic model_bit(input logic [W-1:0] d, input logic p, input int k);
    if (k == 0) return 1'b0;
    if (k <= int'(W)) return d[k-1];
    if (k == int'(W) + 1) return p;
    return 1'b1;
  endfunction

  function automatic logic model_err(input logic [W-1:0] d, input logic p, input logic odd);
    int ones = 0;
    for (int i = 0; i < int'(W); i++) ones += int'(d[i]);
    return p != ((ones % 2 == 1) ? ~odd : odd);
  endfunction

  task automatic wait_ready();
    int n = 0;
    while (!in_ready && n < 200) begin
      @(negedge clk);
      n++;
    end
    check("ready_wait", in_ready, 1'b1);
  endtask

  // Entered at the negedge of the first start-bit cycle; leaves at the frame_done cycle.
  task automatic check_frame(input logic [W-1:0] d, input logic p, input logic e, input int pulse_at);
    for (int k = 0; k < FRAME; k++) begin
      check("tx_bit", tx_serial, model_bit(d, p, k / int'(CPB)));
      check("busy_high", busy, 1'b1);
      check("ready_low", in_ready, 1'b0);
      check("done_low", frame_done, 1'b0);
      check("perr_frame", parity_err, e);
      if (pulse_at >= 0 && k == pulse_at) begin
        in_valid  = 1'b1;
        data_in   = 8'h55;
        parity_in = 1'b1;
      end else if (pulse_at >= 0 && k == pulse_at + 1) begin
        in_valid = 1'b0;
      end
      @(negedge clk);
    end
    check("frame_done", frame_done, 1'b1);
    check("done_tx_idle", tx_serial, 1'b1);
    check("done_busy", busy, 1'b0);
    check("done_ready", in_ready, 1'b1);
    check("done_perr", parity_err, e);
  endtask

  task automatic send(input logic [W-1:0] d, input logic p, input logic e, input int pulse_at);
    wait_ready();
    in_valid  = 1'b1;
    data_in   = d;
    parity_in = p;
    @(negedge clk);
    in_valid = 1'b0;
    check_frame(d, p, e, pulse_at);
    @(negedge clk);
    check("done_one_cycle", frame_done, 1'b0);
    check("idle_tx", tx_serial, 1'b1);
    check("idle_busy", busy, 1'b0);
    check("perr_hold", parity_err, e);
  endtask

  task automatic send_odd(input logic [W-1:0] d, input logic p);
    check("odd_ready", o_ready, 1'b1);
    o_valid = 1'b1;
    o_data  = d;
    o_par   = p;
    @(negedge clk);
    o_valid = 1'b0;
    for (int k = 0; k < int'(W) + 3; k++) begin
      check("odd_tx", o_tx, model_bit(d, p, k));
      check("odd_busy", o_busy, 1'b1);
      check("odd_perr", o_err, model_err(d, p, 1'b1));
      @(negedge clk);
    end
    check("odd_done", o_done, 1'b1);
    check("odd_done_tx", o_tx, 1'b1);
  endtask

  initial begin
    vecs[0] = '{d: 8'h01, p: 1'b1, e: 1'b0, pulse: -1};
    vecs[1] = '{d: 8'hAA, p: 1'b0, e: 1'b0, pulse: -1};
    vecs[2] = '{d: 8'hF0, p: 1'b0, e: 1'b0, pulse: -1};
    vecs[3] = '{d: 8'hFF, p: 1'b1, e: 1'b1, pulse: -1};
    vecs[4] = '{d: 8'h3C, p: 1'b1, e: 1'b1, pulse: 20};

    rst       = 1'b1;
    in_valid  = 1'b1;
    data_in   = 8'h81;
    parity_in = 1'b1;
    o_valid   = 1'b0;
    o_data    = '0;
    o_par     = 1'b0;
    repeat (3) @(negedge clk);
    check("rst_tx", tx_serial, 1'b1);
    check("rst_busy", busy, 1'b0);
    check("rst_done", frame_done, 1'b0);
    check("rst_perr", parity_err, 1'b0);
    check("rst_ready", in_ready, 1'b0);
    rst      = 1'b0;
    in_valid = 1'b0;
    @(negedge clk);
    check("post_rst_ready", in_ready, 1'b1);
    check("post_rst_busy", busy, 1'b0);

    for (int i = 0; i < 5; i++) begin
      send(vecs[i].d, vecs[i].p, vecs[i].e, vecs[i].pulse);
      if (vecs[i].pulse >= 0) begin
        repeat (3) begin
          @(negedge clk);
          check("no_extra_frame", busy, 1'b0);
          check("no_extra_tx", tx_serial, 1'b1);
        end
      end
    end

    // Back-to-back: valid held high, second word taken in the frame_done cycle.
    wait_ready();
    in_valid  = 1'b1;
    data_in   = 8'h00;
    parity_in = 1'b0;
    @(negedge clk);
    data_in   = 8'hFF;
    parity_in = 1'b0;
    check_frame(8'h00, 1'b0, 1'b0, -1);
    @(negedge clk);
    in_valid = 1'b0;
    check_frame(8'hFF, 1'b0, 1'b0, -1);
    @(negedge clk);
    check("b2b_done_clear", frame_done, 1'b0);

    // Reset during data bit 3, with in_valid asserted alongside reset.
    wait_ready();
    in_valid  = 1'b1;
    data_in   = 8'hFF;
    parity_in = 1'b1;
    @(negedge clk);
    in_valid = 1'b0;
    for (int k = 0; k < 4 * int'(CPB) + 1; k++) begin
      check("pre_rst_tx", tx_serial, model_bit(8'hFF, 1'b1, k / int'(CPB)));
      @(negedge clk);
    end
    check("pre_rst_perr", parity_err, 1'b1);
    rst       = 1'b1;
    in_valid  = 1'b1;
    data_in   = 8'h00;
    parity_in = 1'b0;
    @(negedge clk);
    check("mid_rst_tx", tx_serial, 1'b1);
    check("mid_rst_busy", busy, 1'b0);
    check("mid_rst_perr", parity_err, 1'b0);
    check("mid_rst_done", frame_done, 1'b0);
    check("mid_rst_ready", in_ready, 1'b0);
    rst      = 1'b0;
    in_valid = 1'b0;
    @(negedge clk);
    check("after_rst_busy", busy, 1'b0);
    check("after_rst_done", frame_done, 1'b0);
    check("after_rst_tx", tx_serial, 1'b1);
    send(8'hA5, 1'b0, model_err(8'hA5, 1'b0, 1'b0), -1);

    for (int i = 0; i < 24; i++) begin
      logic [W-1:0] d;
      logic         p;
      d = W'($urandom);
      p = 1'($urandom);
      repeat ($urandom_range(0, 3)) @(negedge clk);
      send(d, p, model_err(d, p, 1'b0), -1);
    end

    send_odd(8'hFF, 1'b1);
    @(negedge clk);
    send_odd(8'h01, 1'b1);
    @(negedge clk);
    for (int i = 0; i < 6; i++) begin
      send_odd(W'($urandom), 1'($urandom));
      @(negedge clk);
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/parity_frame_tx.md
Name: parity_frame_tx

Overview:
Serial frame transmitter directly downstream of the parity generator. It accepts a data word plus the generator's parity bit through a valid/ready handshake. It serializes them as start bit, data LSB-first, parity bit and stop bit onto a single line, and flags words whose supplied parity does not match the data. Output feeds the serial link and the receive-side parity checker.

Parameters:
DATA_WIDTH, 8, width of data_in (matches the generator width)
CLKS_PER_BIT, 4, clock cycles each serial bit is held; legal range >= 1
PARITY_ODD, 0, 0 = even convention (expected parity = XOR of data), 1 = odd (expected = XNOR of data)

Ports:
clk  input  1  system clock, all logic on rising edge
rst  input  1  synchronous reset, active-high
data_in  input  DATA_WIDTH  word to transmit
parity_in  input  1  parity bit from the generator
in_valid  input  1  data_in/parity_in valid
in_ready  output  1  block can accept a word this cycle
tx_serial  output  1  serial line; idles high
busy  output  1  frame in progress (any state other than IDLE)
frame_done  output  1  one-cycle pulse after the stop bit completes
parity_err  output  1  registered mismatch flag for the current or last accepted word

Behaviour:
- Clocking: one clock; reset is synchronous and active-high. rst sampled on the rising clk edge only.
- Reset values: state=IDLE, tx_serial=1, busy=0, frame_done=0, parity_err=0, counters=0. in_ready=0 while rst=1.
- in_ready = (state==IDLE) && !rst. This is combinational from the state register.
- Accept: in_valid && in_ready at a rising edge.
  - Latch data_in and parity_in into the shift register.
  - parity_err <= (parity_in != expected), where expected = ^data_in (PARITY_ODD=0) or ~^data_in (PARITY_ODD=1).
  - state -> START.
  - The transmitted parity bit is always parity_in exactly as supplied, never recomputed, so downstream checkers see injected errors.
- in_valid while in_ready=0 is ignored. No buffering, and nothing is latched.
- FSM: IDLE -> START -> DATA -> PARITY -> STOP -> IDLE.
  - tx_serial per state: START=0, DATA=current shift-register LSB, PARITY=latched parity, STOP=1, IDLE=1. tx_serial is registered, so the start bit appears on the cycle after acceptance.
  - Baud counter counts 0..CLKS_PER_BIT-1 within each bit. When it reaches CLKS_PER_BIT-1, the bit ends.
  - In DATA, bit index counts 0..DATA_WIDTH-1. The shift register shifts right at each data-bit end. After index DATA_WIDTH-1 ends, state -> PARITY.
  - When the STOP bit ends, state -> IDLE and frame_done=1 for exactly the first IDLE cycle.
- Frame length: (DATA_WIDTH+3)*CLKS_PER_BIT cycles from the first start-bit cycle through the last stop-bit cycle.
- Back-to-back: a word may be accepted in the frame_done cycle. Its start bit then begins the next cycle, giving exactly one idle-high cycle between frames.
- parity_err holds its value until the next acceptance or reset.
- CLKS_PER_BIT=1: every bit lasts one cycle and no idle-extension cycles are added.
- Reset mid-frame: on the reset edge, the frame is aborted, state -> IDLE and tx_serial=1 on the next cycle. No frame_done is generated. parity_err clears.
- rst and in_valid in the same cycle: reset wins and nothing is accepted.

Test Plan:
- Single frame, W=8, CLKS_PER_BIT=4, data=8'b00000001, parity_in=1 -> tx_serial sequence 0,1,0,0,0,0,0,0,0,1,1, each bit held 4 cycles (44 cycles). frame_done pulses the next cycle and parity_err=0.
- data=8'b10101010, parity_in=0 -> bits 0,0,1,0,1,0,1,0,1,0,1 and parity_err=0. data=8'b11110000, parity_in=0 -> parity_err=0.
- Mismatch: data=8'hFF, parity_in=1 -> parity_err=1 from the cycle after acceptance, and the serial parity bit is 1. With PARITY_ODD=1 the same input gives parity_err=0.
- Back-to-back: hold in_valid high with 8'h00/0 then 8'hFF/0 -> second acceptance occurs in the frame_done cycle, with exactly one idle-high cycle between the first stop bit and the second start bit.
- Busy ignore: pulse in_valid with 8'h55 mid-frame -> in_ready=0, and the current frame continues unchanged with no extra frame.
- Reset mid-frame: assert rst during the DATA bit 3 cycle -> tx_serial=1, busy=0, parity_err=0 next cycle, no frame_done. After deassertion, a new word is accepted normally.
